// File: rtl/counter_ctrl_pkg.sv
// Shared types and constants for the counter sequencing controller.
package counter_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } ctrl_state_t;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/counter_ctrl_sync_edge_det.sv
// Two-flop synchronizer for an asynchronous level pin followed by a
// rising-edge detector; rise is high for exactly one clock.
module sync_edge_det
  import counter_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic rise
);

  logic meta;
  logic sync;
  logic prev;

  // Synchronizer chain plus one delayed copy for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      sync <= 1'b0;
      prev <= 1'b0;
    end else begin
      meta <= pin;
      sync <= meta;
      prev <= sync;
    end
  end

  assign rise = sync & ~prev;

endmodule

// File: rtl/counter_ctrl.sv
// Sequencing controller for the counter datapath: turns start/stop pin
// events into clear/step strobes with a prescaler, terminal compare and
// one-shot or auto-reload behaviour. All outputs are registered.
module counter_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned PRESCALE_W = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  stop_i,
  input  logic                  oneshot_i,
  input  logic                  dir_i,
  input  logic [WIDTH-1:0]      limit_i,
  input  logic [PRESCALE_W-1:0] prescale_i,
  input  logic [WIDTH-1:0]      counter_val_i,
  output logic                  cnt_clr_o,
  output logic                  cnt_en_o,
  output logic                  cnt_dir_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [1:0]            state_o
);

  ctrl_state_t           state;
  ctrl_state_t           state_nx;
  logic [PRESCALE_W-1:0] pre;
  logic [PRESCALE_W-1:0] pre_nx;
  logic [PRESCALE_W-1:0] period;
  logic [WIDTH-1:0]      limit_q;
  logic                  oneshot_q;
  logic                  dir_q;
  logic                  start_ev;
  logic                  stop_ev;
  logic                  latch;
  logic                  clr_nx;
  logic                  en_nx;
  logic                  done_nx;
  logic                  busy_nx;
  logic                  strobe_prev;
  logic                  terminal;

  sync_edge_det u_start (
    .clk   (clk_i),
    .rst_n (rst_i),
    .pin   (start_i),
    .rise  (start_ev)
  );

  sync_edge_det u_stop (
    .clk   (clk_i),
    .rst_n (rst_i),
    .pin   (stop_i),
    .rise  (stop_ev)
  );

  // Next-state, prescaler and strobe decode. Terminal handling takes
  // priority over STOP and stepping; STOP beats START in every state.
  always_comb begin
    state_nx    = state;
    pre_nx      = pre;
    clr_nx      = 1'b0;
    en_nx       = 1'b0;
    done_nx     = 1'b0;
    latch       = 1'b0;
    strobe_prev = cnt_clr_o | cnt_en_o;
    terminal    = !strobe_prev && (counter_val_i == limit_q);
    unique case (state)
      ST_IDLE, ST_DONE: begin
        if (stop_ev) begin
          state_nx = ST_IDLE;
        end else if (start_ev) begin
          latch    = 1'b1;
          clr_nx   = 1'b1;
          pre_nx   = '0;
          state_nx = ST_RUN;
        end
      end
      ST_RUN: begin
        if (terminal) begin
          if (oneshot_q) begin
            state_nx = ST_DONE;
            done_nx  = 1'b1;
          end else begin
            clr_nx = 1'b1;
            pre_nx = '0;
            if (stop_ev) state_nx = ST_PAUSE;
          end
        end else if (stop_ev) begin
          state_nx = ST_PAUSE;
        end else if (pre == period) begin
          // Hold at the period after any strobe so strobes never abut.
          if (!strobe_prev) begin
            en_nx  = 1'b1;
            pre_nx = '0;
          end
        end else begin
          pre_nx = pre + PRESCALE_W'(1);
        end
      end
      ST_PAUSE: begin
        if (stop_ev) begin
          state_nx = ST_IDLE;
        end else if (start_ev) begin
          state_nx = ST_RUN;
        end
      end
    endcase
    busy_nx = (state_nx == ST_RUN) || (state_nx == ST_PAUSE);
  end

  // State, prescaler and registered strobe outputs.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state     <= ST_IDLE;
      pre       <= '0;
      cnt_clr_o <= 1'b0;
      cnt_en_o  <= 1'b0;
      done_o    <= 1'b0;
      busy_o    <= 1'b0;
    end else begin
      state     <= state_nx;
      pre       <= pre_nx;
      cnt_clr_o <= clr_nx;
      cnt_en_o  <= en_nx;
      done_o    <= done_nx;
      busy_o    <= busy_nx;
    end
  end

  // Configuration captured only on START from IDLE or DONE.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      limit_q   <= '0;
      period    <= '0;
      oneshot_q <= 1'b0;
      dir_q     <= DIR_UP;
    end else if (latch) begin
      limit_q   <= limit_i;
      period    <= prescale_i;
      oneshot_q <= oneshot_i;
      dir_q     <= dir_i;
    end
  end

  assign cnt_dir_o = dir_q;
  assign state_o   = state;

endmodule
